// File: rtl/pipeline_controller_if.sv
// Decode-stage instruction fields, stage register indices and the
// control/hazard outputs of the RV32I pipeline controller.
interface pipeline_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [4:0] Rs1D;
    logic [4:0] Rs2D;
    logic [4:0] Rs1E;
    logic [4:0] Rs2E;
    logic [4:0] RdE;
    logic [4:0] RdM;
    logic [4:0] RdW;
    logic       ZeroE;

    logic [2:0] ImmSrcD;
    logic [2:0] ALUControlE;
    logic       ALUSrcE;
    logic       PCSrcE;
    logic       MemWriteM;
    logic [1:0] ResultSrcW;
    logic       RegWriteW;
    logic       StallF;
    logic       StallD;
    logic       FlushD;
    logic       FlushE;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;

    modport master (
        output op, funct3, funct7b5, Rs1D, Rs2D,
        output Rs1E, Rs2E, RdE, RdM, RdW, ZeroE,
        input  ImmSrcD, ALUControlE, ALUSrcE, PCSrcE,
        input  MemWriteM, ResultSrcW, RegWriteW,
        input  StallF, StallD, FlushD, FlushE,
        input  ForwardAE, ForwardBE
    );

    modport slave (
        input  op, funct3, funct7b5, Rs1D, Rs2D,
        input  Rs1E, Rs2E, RdE, RdM, RdW, ZeroE,
        output ImmSrcD, ALUControlE, ALUSrcE, PCSrcE,
        output MemWriteM, ResultSrcW, RegWriteW,
        output StallF, StallD, FlushD, FlushE,
        output ForwardAE, ForwardBE
    );
endinterface

// File: rtl/pipeline_controller.sv
// RV32I five-stage pipeline controller: main/ALU decode, D/E/M/W control
// registers, branch resolution, forwarding and load-use hazard logic.
module pipeline_controller (
    input  logic                  clk,
    input  logic                  resetn,
    pipeline_controller_if.slave  bus
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] funct3;
        logic [2:0] alu_control;
        logic       alu_src;
    } de_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } em_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } mw_t;

    de_t        dec;
    logic [1:0] alu_op;
    logic [2:0] imm_src;

    de_t de_d, de_q;
    em_t em_d, em_q;
    mw_t mw_d, mw_q;

    logic lw_stall;
    logic pc_src;
    logic flush_e;

    always_comb begin : main_decode
        dec     = '0;
        alu_op  = 2'b00;
        imm_src = 3'b000;
        case (bus.op)
            OP_LW: begin
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b01;
                dec.alu_src    = 1'b1;
            end
            OP_SW: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_src       = 3'b001;
            end
            OP_R: begin
                dec.reg_write = 1'b1;
                alu_op        = 2'b10;
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                alu_op        = 2'b10;
            end
            OP_B: begin
                dec.branch = 1'b1;
                imm_src    = 3'b010;
                alu_op     = 2'b01;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = 2'b10;
                imm_src        = 3'b011;
            end
            default: ;
        endcase
        dec.funct3 = bus.funct3;

        // funct7b5 only selects sub for register-register ops
        case (alu_op)
            2'b00: dec.alu_control = ALU_ADD;
            2'b01: dec.alu_control = ALU_SUB;
            default: begin
                case (bus.funct3)
                    3'b000: dec.alu_control =
                        (bus.op == OP_R && bus.funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010: dec.alu_control = ALU_SLT;
                    3'b110: dec.alu_control = ALU_OR;
                    3'b111: dec.alu_control = ALU_AND;
                    default: dec.alu_control = ALU_ADD;
                endcase
            end
        endcase
    end

    always_comb begin : hazard
        pc_src = de_q.jump |
                 (de_q.branch &
                  (((de_q.funct3 == 3'b000) & bus.ZeroE) |
                   ((de_q.funct3 == 3'b001) & ~bus.ZeroE)));
        lw_stall = (de_q.result_src == 2'b01) &&
                   (bus.RdE != 5'd0) &&
                   ((bus.Rs1D == bus.RdE) || (bus.Rs2D == bus.RdE));
        flush_e = lw_stall | pc_src;
    end

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != 5'd0) begin
            if (we_m && rs == rd_m)
                sel = 2'b10;
            else if (we_w && rs == rd_w)
                sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin : next_stage
        de_d = flush_e ? '0 : dec;

        em_d            = '0;
        em_d.reg_write  = de_q.reg_write;
        em_d.result_src = de_q.result_src;
        em_d.mem_write  = de_q.mem_write;

        mw_d            = '0;
        mw_d.reg_write  = em_q.reg_write;
        mw_d.result_src = em_q.result_src;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            de_q <= '0;
            em_q <= '0;
            mw_q <= '0;
        end else begin
            de_q <= de_d;
            em_q <= em_d;
            mw_q <= mw_d;
        end
    end

    assign bus.ImmSrcD     = imm_src;
    assign bus.ALUControlE = de_q.alu_control;
    assign bus.ALUSrcE     = de_q.alu_src;
    assign bus.PCSrcE      = pc_src;
    assign bus.MemWriteM   = em_q.mem_write;
    assign bus.ResultSrcW  = mw_q.result_src;
    assign bus.RegWriteW   = mw_q.reg_write;

    assign bus.StallF = lw_stall;
    assign bus.StallD = lw_stall;
    assign bus.FlushD = pc_src;
    assign bus.FlushE = flush_e;

    assign bus.ForwardAE = fwd_sel(bus.Rs1E, bus.RdM, em_q.reg_write,
                                   bus.RdW, mw_q.reg_write);
    assign bus.ForwardBE = fwd_sel(bus.Rs2E, bus.RdM, em_q.reg_write,
                                   bus.RdW, mw_q.reg_write);

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: stage control checked through a
// cycle-tagged scoreboard, hazard outputs checked per step.
module tb_pipeline_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] NOP = 7'b0000000;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    pipeline_controller_if bus ();

    pipeline_controller dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct packed {
        logic [2:0] alu;
        logic       asrc;
        logic       mw;
        logic       rw;
        logic [1:0] rs;
        logic [2:0] imm;
    } exp_t;

    typedef struct {
        int         cyc;
        int         sel;
        logic [2:0] val;
    } sb_t;

    sb_t sb[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  cyc = 0;

    logic [4:0] pe_rs1, pe_rs2, pe_rd, pm_rd, pw_rd;
    logic [4:0] d_rs1, d_rs2, d_rd;
    logic       zero;
    bit         kill_now;

    function automatic logic [2:0] ref_alu(input logic [2:0] f3,
                                           input logic sub);
        if (f3 == 3'b000) return sub ? 3'b001 : 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    function automatic exp_t ref_dec(input logic [6:0] o,
                                     input logic [2:0] f3,
                                     input logic f7);
        exp_t e;
        e = '0;
        if (o == LW) begin
            e.asrc = 1'b1; e.rw = 1'b1; e.rs = 2'b01;
        end else if (o == SW) begin
            e.asrc = 1'b1; e.mw = 1'b1; e.imm = 3'b001;
        end else if (o == RT) begin
            e.rw = 1'b1; e.alu = ref_alu(f3, f7);
        end else if (o == IT) begin
            e.rw = 1'b1; e.asrc = 1'b1; e.alu = ref_alu(f3, 1'b0);
        end else if (o == BR) begin
            e.alu = 3'b001; e.imm = 3'b010;
        end else if (o == JL) begin
            e.rw = 1'b1; e.rs = 2'b10; e.imm = 3'b011;
        end
        return e;
    endfunction

    function automatic string sel_name(input int s);
        case (s)
            0: return "ALUControlE";
            1: return "ALUSrcE";
            2: return "MemWriteM";
            3: return "RegWriteW";
            default: return "ResultSrcW";
        endcase
    endfunction

    function automatic logic [2:0] sel_obs(input int s);
        case (s)
            0: return bus.ALUControlE;
            1: return {2'b00, bus.ALUSrcE};
            2: return {2'b00, bus.MemWriteM};
            3: return {2'b00, bus.RegWriteW};
            default: return {1'b0, bus.ResultSrcW};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [2:0] o,
                       input logic [2:0] x);
        vectors++;
        assert (o === x) else begin
            miscompares++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h",
                   tag, cyc, o, x);
        end
    endtask

    task automatic push(input int c, input int s, input logic [2:0] v);
        sb.push_back('{c, s, v});
    endtask

    task automatic drive(input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd,
                         input bit kill);
        exp_t e, k;
        bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7;
        bus.Rs1D = r1; bus.Rs2D = r2;
        bus.Rs1E = pe_rs1; bus.Rs2E = pe_rs2; bus.RdE = pe_rd;
        bus.RdM = pm_rd; bus.RdW = pw_rd; bus.ZeroE = zero;
        e = ref_dec(o, f3, f7);
        k = kill ? '0 : e;
        push(cyc + 1, 0, k.alu);
        push(cyc + 1, 1, {2'b00, k.asrc});
        push(cyc + 2, 2, {2'b00, k.mw});
        push(cyc + 3, 3, {2'b00, k.rw});
        push(cyc + 3, 4, {1'b0, k.rs});
        d_rs1 = r1; d_rs2 = r2; d_rd = rd; kill_now = kill;
        @(negedge clk);
        chk("ImmSrcD", bus.ImmSrcD, e.imm);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                chk(sel_name(sb[i].sel), sel_obs(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
        pw_rd = pm_rd;
        pm_rd = pe_rd;
        if (kill_now) begin
            pe_rs1 = '0; pe_rs2 = '0; pe_rd = '0;
        end else begin
            pe_rs1 = d_rs1; pe_rs2 = d_rs2; pe_rd = d_rd;
        end
    endtask

    // fl = {stall, flushD, flushE, pcsrc}
    task automatic hz(input string t, input logic [1:0] fa,
                      input logic [1:0] fb, input logic [3:0] fl);
        chk({t, ".FwdA"},   {1'b0, bus.ForwardAE}, {1'b0, fa});
        chk({t, ".FwdB"},   {1'b0, bus.ForwardBE}, {1'b0, fb});
        chk({t, ".StallF"}, {2'b00, bus.StallF}, {2'b00, fl[3]});
        chk({t, ".StallD"}, {2'b00, bus.StallD}, {2'b00, fl[3]});
        chk({t, ".FlushD"}, {2'b00, bus.FlushD}, {2'b00, fl[2]});
        chk({t, ".FlushE"}, {2'b00, bus.FlushE}, {2'b00, fl[1]});
        chk({t, ".PCSrcE"}, {2'b00, bus.PCSrcE}, {2'b00, fl[0]});
    endtask

    task automatic step(input string t, input logic [6:0] o,
                        input logic [2:0] f3, input logic f7,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [1:0] fa,
                        input logic [1:0] fb, input logic [3:0] fl);
        drive(o, f3, f7, r1, r2, rd, fl[1]);
        hz(t, fa, fb, fl);
        adv();
    endtask

    task automatic reset_check(input string t);
        resetn = 1'b0;
        bus.op = SW;
        #1;
        chk({t, ".RegWriteW"},   {2'b00, bus.RegWriteW}, 3'd0);
        chk({t, ".MemWriteM"},   {2'b00, bus.MemWriteM}, 3'd0);
        chk({t, ".ResultSrcW"},  {1'b0, bus.ResultSrcW}, 3'd0);
        chk({t, ".ALUControlE"}, bus.ALUControlE, 3'd0);
        chk({t, ".ALUSrcE"},     {2'b00, bus.ALUSrcE}, 3'd0);
        hz(t, 2'd0, 2'd0, 4'b0000);
        chk({t, ".ImmSrcD"},     bus.ImmSrcD, 3'b001);
        sb.delete();
        pe_rs1 = '0; pe_rs2 = '0; pe_rd = '0; pm_rd = '0; pw_rd = '0;
        kill_now = 1'b0;
        bus.op = NOP; bus.Rs1D = '0; bus.Rs2D = '0;
        bus.Rs1E = '0; bus.Rs2E = '0; bus.RdE = '0;
        bus.RdM = '0; bus.RdW = '0; bus.ZeroE = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        push(cyc, 0, 3'd0);
        push(cyc, 1, 3'd0);
        for (int k = 0; k < 2; k++) push(cyc + k, 2, 3'd0);
        for (int k = 0; k < 3; k++) begin
            push(cyc + k, 3, 3'd0);
            push(cyc + k, 4, 3'd0);
        end
    endtask

    initial begin
        bus.funct3 = '0; bus.funct7b5 = 1'b0; zero = 1'b0;
        reset_check("rst0");

        // forwarding from M then W
        step("a0", RT, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 2'd0, 2'd0, 4'b0000);
        step("a1", RT, 3'b000, 1'b1, 5'd3, 5'd5, 5'd4, 2'd0, 2'd0, 4'b0000);
        step("a2", RT, 3'b110, 1'b0, 5'd3, 5'd7, 5'd6, 2'd2, 2'd0, 4'b0000);
        step("a3", IT, 3'b111, 1'b0, 5'd3, 5'd4, 5'd8, 2'd1, 2'd0, 4'b0000);
        step("a4", NOP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd1, 4'b0000);

        // M beats W when both hold the same destination
        step("b0", RT, 3'b010, 1'b0, 5'd1, 5'd1, 5'd9, 2'd0, 2'd0, 4'b0000);
        step("b1", RT, 3'b111, 1'b0, 5'd2, 5'd2, 5'd9, 2'd0, 2'd0, 4'b0000);
        step("b2", RT, 3'b000, 1'b0, 5'd9, 5'd9, 5'd10, 2'd0, 2'd0, 4'b0000);
        step("b3", NOP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 2'd2, 2'd2, 4'b0000);

        // load-use stall then W forward
        step("c0", LW, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5, 2'd0, 2'd0, 4'b0000);
        step("c1", RT, 3'b000, 1'b0, 5'd5, 5'd1, 5'd6, 2'd0, 2'd0, 4'b1010);
        step("c2", RT, 3'b000, 1'b0, 5'd5, 5'd1, 5'd6, 2'd0, 2'd0, 4'b0000);
        step("c3", NOP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 2'd1, 2'd0, 4'b0000);

        // x0 never stalls nor forwards; sw data forwarded from M
        step("d0", LW, 3'b010, 1'b0, 5'd2, 5'd0, 5'd0, 2'd0, 2'd0, 4'b0000);
        step("d1", RT, 3'b000, 1'b0, 5'd0, 5'd0, 5'd7, 2'd0, 2'd0, 4'b0000);
        step("d2", SW, 3'b010, 1'b0, 5'd0, 5'd7, 5'd7, 2'd0, 2'd0, 4'b0000);
        step("d3", NOP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd2, 4'b0000);

        // branches
        step("e0", BR, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 2'd0, 2'd0, 4'b0000);
        zero = 1'b1;
        step("e1", IT, 3'b000, 1'b0, 5'd1, 5'd0, 5'd11, 2'd0, 2'd0, 4'b0111);
        zero = 1'b0;
        step("e2", NOP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 4'b0000);
        step("e3", BR, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 2'd0, 2'd0, 4'b0000);
        step("e4", IT, 3'b000, 1'b0, 5'd1, 5'd0, 5'd11, 2'd0, 2'd0, 4'b0000);
        step("e5", BR, 3'b001, 1'b0, 5'd1, 5'd2, 5'd0, 2'd0, 2'd0, 4'b0000);
        step("e6", NOP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 4'b0111);
        step("e7", BR, 3'b100, 1'b0, 5'd11, 5'd2, 5'd0, 2'd0, 2'd0, 4'b0000);
        zero = 1'b1;
        step("e8", NOP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 4'b0000);
        zero = 1'b0;

        // jal: redirect in E, PC+4 written back three cycles later
        step("f0", JL, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 2'd0, 2'd0, 4'b0000);
        step("f1", RT, 3'b000, 1'b0, 5'd1, 5'd1, 5'd12, 2'd0, 2'd0, 4'b0111);
        step("f2", NOP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 4'b0000);
        step("f3", NOP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 4'b0000);

        // reset while a load-use stall is active
        step("h0", LW, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5, 2'd0, 2'd0, 4'b0000);
        drive(RT, 3'b000, 1'b0, 5'd5, 5'd1, 5'd6, 1'b1);
        hz("h1", 2'd0, 2'd0, 4'b1010);
        #2;
        reset_check("rst1");

        // unknown opcodes behave as bubbles
        step("u0", 7'b1111111, 3'b000, 1'b0, 5'd3, 5'd4, 5'd5, 2'd0, 2'd0, 4'b0000);
        step("u1", 7'b0110111, 3'b000, 1'b0, 5'd5, 5'd5, 5'd6, 2'd0, 2'd0, 4'b0000);
        step("u2", 7'b1100111, 3'b000, 1'b0, 5'd6, 5'd5, 5'd7, 2'd0, 2'd0, 4'b0000);
        step("u3", 7'b0000001, 3'b010, 1'b1, 5'd7, 5'd6, 5'd8, 2'd0, 2'd0, 4'b0000);
        for (int n = 0; n < 3; n++)
            step("z", NOP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameters: none; all widths fixed for RV32I pipelined core.
REQ-002 clk  in  1  single core clock; all state updates on rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 op  in  7  opcode of instruction in Decode.
REQ-005 funct3  in  3  Decode funct3.
REQ-006 funct7b5  in  1  Decode instruction bit 30.
REQ-007 Rs1D, Rs2D  in  5 each  Decode source register indices.
REQ-008 Rs1E, Rs2E, RdE  in  5 each  Execute register indices.
REQ-009 RdM, RdW  in  5 each  Memory/Writeback destination indices.
REQ-010 ZeroE  in  1  ALU zero flag from Execute.
REQ-011 ImmSrcD  out  3  immediate type: 000 I, 001 S, 010 B, 011 J.
REQ-012 ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-013 ALUSrcE  out  1  1 = immediate as ALU operand B.
REQ-014 PCSrcE  out  1  1 = next PC from branch/jump target.
REQ-015 MemWriteM  out  1  data memory write enable.
REQ-016 ResultSrcW  out  2  00 ALU result, 01 load data, 10 PC+4.
REQ-017 RegWriteW  out  1  register file write enable.
REQ-018 StallF, StallD, FlushD, FlushE  out  1 each  hazard controls.
REQ-019 ForwardAE, ForwardBE  out  2 each  00 register file, 01 ResultW, 10 ALUResultM.

Function
REQ-020 Decode (combinational): lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, branch 1100011, jal 1101111; any other opcode decodes as bubble (RegWrite, MemWrite, Branch, Jump = 0).
REQ-021 ALU decode: lw/sw/jal -> add; branch -> sub; R/I funct3 000 -> sub only when R-type and funct7b5=1, else add; 010 -> slt; 110 -> or; 111 -> and; other funct3 -> add.
REQ-022 D->E register holds RegWrite, ResultSrc, MemWrite, Jump, Branch, branch funct3, ALUControl, ALUSrc; loads every cycle; synchronously clears to all-zero when FlushE=1.
REQ-023 E->M register holds RegWrite, ResultSrc, MemWrite; M->W register holds RegWrite, ResultSrc; neither is flushed or stalled.
REQ-024 Control latency: Decode bits appear on E outputs 1 cycle, M outputs 2 cycles, W outputs 3 cycles after Decode.
REQ-025 PCSrcE = JumpE OR (BranchE AND ((funct3E=000 AND ZeroE) OR (funct3E=001 AND NOT ZeroE))); other branch funct3 never taken.
REQ-026 ForwardAE = 10 if Rs1E=RdM, RegWriteM=1, Rs1E!=0; else 01 if Rs1E=RdW, RegWriteW=1, Rs1E!=0; else 00; ForwardBE identical using Rs2E; M match takes priority when both match.
REQ-027 Load-use: lwStall = ResultSrcE=01 AND RdE!=0 AND (Rs1D=RdE OR Rs2D=RdE).
REQ-028 StallF = StallD = lwStall; FlushD = PCSrcE; FlushE = lwStall OR PCSrcE.
REQ-029 lwStall and PCSrcE in the same cycle: both flush outputs asserted, stalls asserted; redirect wins (Decode squashed).
REQ-030 Register index x0 never forwards and never causes a stall.

Reset
REQ-031 resetn=0 immediately clears all three control pipeline registers regardless of clk.
REQ-032 During and after reset until first Decode propagates: RegWriteW=0, MemWriteM=0, ResultSrcW=00, ALUControlE=000, ALUSrcE=0, PCSrcE=0, Forward*=00, Stall*=0, Flush*=0; ImmSrcD follows op.
REQ-033 Reset asserted mid-stall or mid-branch discards all in-flight control; no write enable asserts in the cycle after release.

Verification
REQ-034 R-type add x3 with x3 read by next instruction -> ForwardAE=10 on that instruction's Execute cycle; the cycle after, a third reader sees 01.
REQ-035 lw x5 then add x6,x5,x1 -> StallF=StallD=FlushE=1 for exactly one cycle, then ForwardAE=01.
REQ-036 beq with ZeroE=1 -> PCSrcE=1, FlushD=FlushE=1 one cycle; same with ZeroE=0 -> all 0.
REQ-037 jal x1 -> PCSrcE=1 in Execute; three cycles after Decode ResultSrcW=10, RegWriteW=1.
REQ-038 Instruction writing x0 followed by reader of x0 -> Forward*=00, no stall; sw -> MemWriteM=1 two cycles after Decode, RegWriteW=0.
REQ-039 resetn dropped while lwStall=1 -> all outputs at REQ-032 values asynchronously; after release, unknown opcode stream produces no write enables.
